// File: rtl/pwm_sched_pkg.sv
// Shared types and widths for the PWM duty scheduler.
package pwm_sched_pkg;

    localparam int unsigned DUTY_W   = 11;
    localparam int unsigned SPD_W    = 12;
    localparam logic [10:0] PRD_LAST = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DECEL = 2'd2,
        DWELL = 2'd3
    } ch_state_t;

endpackage

// File: rtl/pwm_ch_sched.sv
// One PWM channel: signed speed to saturated magnitude, per-period slew and
// the decel/dwell sequence that guards every direction reversal.
module pwm_ch_sched
    import pwm_sched_pkg::*;
#(
    parameter int unsigned STEP     = 64,
    parameter int unsigned MAX_DUTY = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              en,
    input  logic [SPD_W-1:0]  spd,
    output logic [DUTY_W-1:0] duty,
    output logic              rev
);

    localparam logic [11:0] STEP_W = 12'(STEP);
    localparam logic [11:0] MAX_W  = 12'(MAX_DUTY);

    ch_state_t         state_q, state_d;
    logic [10:0]       duty_q, duty_d;
    logic              rev_q, rev_d;

    logic [11:0]       mag;
    logic [11:0]       tgt_mag;
    logic              tgt_rev;
    logic              hold_dir;
    logic [11:0]       duty12;
    logic [11:0]       up;
    logic [11:0]       dn;
    logic [11:0]       slew;

    // Target magnitude/direction and the slewed duty toward it.
    always_comb begin
        // -2048 negates to 12'h800, read as unsigned 2048, then saturates.
        mag      = spd[11] ? (~spd + 12'd1) : spd;
        tgt_mag  = (mag > MAX_W) ? MAX_W : mag;
        tgt_rev  = spd[11];
        hold_dir = (spd == '0) || (tgt_rev == rev_q);
        duty12   = {1'b0, duty_q};
        up       = duty12 + STEP_W;
        dn       = duty12 - STEP_W;
        if (duty12 < tgt_mag) begin
            slew = (up > tgt_mag) ? tgt_mag : up;
        end else if (duty12 > tgt_mag) begin
            slew = ((duty12 - tgt_mag) > STEP_W) ? dn : tgt_mag;
        end else begin
            slew = tgt_mag;
        end
    end

    // Channel FSM; state only moves on a period tick, except the enable kill.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        rev_d   = rev_q;
        if (!en) begin
            state_d = IDLE;
            duty_d  = '0;
            rev_d   = 1'b0;
        end else if (tick) begin
            unique case (state_q)
                IDLE: begin
                    rev_d   = tgt_rev;
                    duty_d  = (tgt_mag > STEP_W) ? STEP_W[10:0] : tgt_mag[10:0];
                    state_d = RUN;
                end
                RUN, DECEL: begin
                    if (hold_dir) begin
                        duty_d  = slew[10:0];
                        state_d = RUN;
                    end else if (duty12 > STEP_W) begin
                        duty_d  = dn[10:0];
                        state_d = DECEL;
                    end else begin
                        duty_d  = '0;
                        state_d = DWELL;
                    end
                end
                DWELL: begin
                    if (spd != '0) begin
                        rev_d = tgt_rev;
                    end
                    duty_d  = '0;
                    state_d = RUN;
                end
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
            rev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            rev_q   <= rev_d;
        end
    end

    assign duty = duty_q;
    assign rev  = rev_q;

endmodule

// File: rtl/pwm_duty_sched.sv
// Two-channel PWM duty scheduler: shared period counter plus left/right
// channel schedulers that only update on the period boundary.
module pwm_duty_sched
    import pwm_sched_pkg::*;
#(
    parameter int unsigned STEP     = 64,
    parameter int unsigned MAX_DUTY = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [SPD_W-1:0]  lft_spd,
    input  logic [SPD_W-1:0]  rght_spd,
    output logic [DUTY_W-1:0] lft_duty,
    output logic [DUTY_W-1:0] rght_duty,
    output logic              lft_rev,
    output logic              rght_rev,
    output logic              prd_tick
);

    logic [10:0] cnt_q, cnt_d;

    // Free-running period counter, phase-aligned with the PWM counters.
    always_comb begin
        cnt_d = cnt_q + 11'd1;
    end

    // Period counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign prd_tick = (cnt_q == PRD_LAST);

    pwm_ch_sched #(
        .STEP     (STEP),
        .MAX_DUTY (MAX_DUTY)
    ) u_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (prd_tick),
        .en    (en),
        .spd   (lft_spd),
        .duty  (lft_duty),
        .rev   (lft_rev)
    );

    pwm_ch_sched #(
        .STEP     (STEP),
        .MAX_DUTY (MAX_DUTY)
    ) u_rght (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (prd_tick),
        .en    (en),
        .spd   (rght_spd),
        .duty  (rght_duty),
        .rev   (rght_rev)
    );

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Scoreboard bench: stimulus pushes the expected post-tick outputs, a monitor
// pops and compares them after every period boundary.
module tb_pwm_duty_sched;

    typedef struct {
        logic [10:0] ld;
        logic        lr;
        logic [10:0] rd;
        logic        rr;
        logic [10:0] fld;
        logic        flr;
        logic [10:0] frd;
        logic        frr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        en_f = 1'b1;
    logic [11:0] lft_spd = '0, rght_spd = '0;
    logic [11:0] f_lft_spd = '0, f_rght_spd = '0;
    logic [10:0] lft_duty, rght_duty, f_lft_duty, f_rght_duty;
    logic        lft_rev, rght_rev, f_lft_rev, f_rght_rev;
    logic        prd_tick, f_prd_tick;

    int   vectors = 0;
    int   errors = 0;
    int   chk_idx = 0;
    int   stab_bad = 0;
    logic mon_on = 1'b0;
    logic chk_req = 1'b0;
    logic pend = 1'b0;
    logic tick_prev = 1'b0;
    logic [47:0] outs_prev = '0;
    logic prd_done = 1'b0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    pwm_duty_sched u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .lft_duty  (lft_duty),
        .rght_duty (rght_duty),
        .lft_rev   (lft_rev),
        .rght_rev  (rght_rev),
        .prd_tick  (prd_tick)
    );

    // Large step so the saturation/reversal path fits in a few periods.
    pwm_duty_sched #(
        .STEP     (1000),
        .MAX_DUTY (2000)
    ) u_dut_fast (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en_f),
        .lft_spd   (f_lft_spd),
        .rght_spd  (f_rght_spd),
        .lft_duty  (f_lft_duty),
        .rght_duty (f_rght_duty),
        .lft_rev   (f_lft_rev),
        .rght_rev  (f_rght_rev),
        .prd_tick  (f_prd_tick)
    );

    task automatic cmp(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    wire [47:0] outs = {lft_duty, lft_rev, rght_duty, rght_rev,
                        f_lft_duty, f_lft_rev, f_rght_duty, f_rght_rev};

    // Monitor: compare after each tick edge and flag any off-tick output change.
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (pend) begin
                chk_idx++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL chk%0d: output event with empty scoreboard", chk_idx);
                end else begin
                    e = sb_q.pop_front();
                    cmp($sformatf("chk%0d lft_duty", chk_idx), int'(lft_duty), int'(e.ld));
                    cmp($sformatf("chk%0d lft_rev", chk_idx), int'(lft_rev), int'(e.lr));
                    cmp($sformatf("chk%0d rght_duty", chk_idx), int'(rght_duty), int'(e.rd));
                    cmp($sformatf("chk%0d rght_rev", chk_idx), int'(rght_rev), int'(e.rr));
                    cmp($sformatf("chk%0d f_lft_duty", chk_idx), int'(f_lft_duty), int'(e.fld));
                    cmp($sformatf("chk%0d f_lft_rev", chk_idx), int'(f_lft_rev), int'(e.flr));
                    cmp($sformatf("chk%0d f_rght_duty", chk_idx), int'(f_rght_duty),
                        int'(e.frd));
                    cmp($sformatf("chk%0d f_rght_rev", chk_idx), int'(f_rght_rev), int'(e.frr));
                end
            end
            if (!tick_prev && en && (outs != outs_prev)) begin
                errors++;
                stab_bad++;
                $display("FAIL off_tick_change: got %h want %h", outs, outs_prev);
            end
        end
        pend      <= prd_tick || chk_req;
        tick_prev <= prd_tick;
        outs_prev <= outs;
    end

    // First tick at clk 2047 after release, then one every 2048 clks.
    initial begin
        int n;
        int m;
        wait (rst_n === 1'b1);
        n = 0;
        while (!prd_tick && n < 5000) begin
            @(posedge clk);
            n++;
            #1;
        end
        cmp("first_tick_clk", n, 2047);
        m = 0;
        do begin
            @(posedge clk);
            m++;
            #1;
        end while (!prd_tick && m < 5000);
        cmp("tick_period", m, 2048);
        prd_done = 1'b1;
    end

    task automatic wait_tick();
        int n = 0;
        while (!prd_tick && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            errors++;
            $display("FAIL tick_timeout: got no tick within %0d clks want tick", n);
        end
        @(negedge clk);
    endtask

    // Apply inputs for the coming period and queue the post-tick outputs.
    task automatic step(input int ls, input int rs, input int fs,
                        input int ld, input int lr, input int rd, input int rr,
                        input int frd, input int frr);
        exp_t e;
        lft_spd    = 12'(ls);
        rght_spd   = 12'(rs);
        f_rght_spd = 12'(fs);
        e.ld  = 11'(ld);
        e.lr  = 1'(lr);
        e.rd  = 11'(rd);
        e.rr  = 1'(rr);
        e.fld = '0;
        e.flr = 1'b0;
        e.frd = 11'(frd);
        e.frr = 1'(frr);
        sb_q.push_back(e);
        wait_tick();
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        cmp("rst lft_duty", int'(lft_duty), 0);
        cmp("rst rght_duty", int'(rght_duty), 0);
        cmp("rst lft_rev", int'(lft_rev), 0);
        cmp("rst rght_rev", int'(rght_rev), 0);
        cmp("rst prd_tick", int'(prd_tick), 0);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        //    lspd  rspd  fspd   ld  lr   rd rr   frd frr
        step(  300,  200, 2047,  64, 0,  64, 0, 1000, 0);
        step(  300,  200, 2047, 128, 0, 128, 0, 2000, 0);
        step(  300,  200, 2047, 192, 0, 192, 0, 2000, 0);
        step(  300,  200,-2048, 256, 0, 200, 0, 1000, 0);
        step(  300, -100,-2048, 300, 0, 136, 0,    0, 0);
        step(  300, -100,-2048, 300, 0,  72, 0,    0, 1);
        step(  200,  150,-2048, 236, 0, 136, 0, 1000, 1);
        step(  200,  150,-2048, 200, 0, 150, 0, 2000, 1);
        step( -100,  150,-2048, 136, 0, 150, 0, 2000, 1);
        step( -100,  150,-2048,  72, 0, 150, 0, 2000, 1);
        step( -100,  150,-2048,   8, 0, 150, 0, 2000, 1);
        step( -100,  150,-2048,   0, 0, 150, 0, 2000, 1);
        step( -100,  150,-2048,   0, 1, 150, 0, 2000, 1);
        step( -100,  150,-2048,  64, 1, 150, 0, 2000, 1);
        step( -100,  150,-2048, 100, 1, 150, 0, 2000, 1);
        step( -128,  150,-2048, 128, 1, 150, 0, 2000, 1);
        step(    0,  150,-2048,  64, 1, 150, 0, 2000, 1);
        step(    0,  150,-2048,   0, 1, 150, 0, 2000, 1);
        step(    0,  150,-2048,   0, 1, 150, 0, 2000, 1);
        step(    0,  256,-2048,   0, 1, 214, 0, 2000, 1);
        step(    0,  256,-2048,   0, 1, 256, 0, 2000, 1);

        // Drop enable mid-period: main DUT clears one clk later, not at a tick.
        repeat (1000) @(negedge clk);
        #1;
        en      = 1'b0;
        chk_req = 1'b1;
        e.ld  = '0;
        e.lr  = 1'b0;
        e.rd  = '0;
        e.rr  = 1'b0;
        e.fld = '0;
        e.flr = 1'b0;
        e.frd = 11'd2000;
        e.frr = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        #1;
        chk_req = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        en = 1'b1;
        @(negedge clk);
        step(    0,  256,-2048,   0, 0,  64, 0, 2000, 1);

        repeat (4) @(negedge clk);
        cmp("scoreboard_drained", sb_q.size(), 0);
        cmp("period_check_done", int'(prd_done), 1);
        cmp("off_tick_changes", stab_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
